// File: rtl/cpu_sequencer_if.sv
// Handshake and phase-strobe bundle between the MU0 sequencer and its surroundings.
// The master drives the control pulses and the fetch handshake; the slave returns the phase strobes and status.
interface cpu_sequencer_if #(
    parameter int ICNT_W = 16
);
    logic              START;
    logic              STEP;
    logic              BREAK;
    logic              MEM_READY;
    logic [3:0]        IR_IN;
    logic              FETCH;
    logic              EXEC1;
    logic              EXEC2;
    logic [3:0]        OP;
    logic              HALTED;
    logic              ILLEGAL;
    logic              INSTR_DONE;
    logic [ICNT_W-1:0] INSTR_COUNT;

    modport master (
        output START, STEP, BREAK, MEM_READY, IR_IN,
        input  FETCH, EXEC1, EXEC2, OP, HALTED, ILLEGAL, INSTR_DONE, INSTR_COUNT
    );

    modport slave (
        input  START, STEP, BREAK, MEM_READY, IR_IN,
        output FETCH, EXEC1, EXEC2, OP, HALTED, ILLEGAL, INSTR_DONE, INSTR_COUNT
    );
endinterface

// File: rtl/cpu_sequencer.sv
// MU0 control-unit phase generator: FETCH/EXEC1/EXEC2 strobes, latched opcode,
// STP halt, single-step/break control and a retired-instruction counter.
module cpu_sequencer #(
    parameter int ICNT_W     = 16,
    parameter bit AUTO_START = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    cpu_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC1,
        S_EXEC2,
        S_HALT
    } state_e;

    localparam state_e     RST_STATE  = AUTO_START ? S_FETCH : S_IDLE;
    localparam logic       RST_RUN    = AUTO_START;
    localparam logic [3:0] OP_LDA     = 4'b0000;
    localparam logic [3:0] OP_STP     = 4'b0111;
    localparam logic [3:0] OP_ILL_MIN = 4'b1011;

    state_e            r_state;
    state_e            w_state_nxt;
    state_e            w_end_state;
    logic              r_run_mode;
    logic              w_run_nxt;
    logic              w_start;
    logic [3:0]        r_op;
    logic              r_illegal;
    logic [ICNT_W-1:0] r_count;
    logic              w_fetch;
    logic              w_exec1;
    logic              w_exec2;
    logic              w_halted;
    logic              w_instr_done;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RST_STATE;
            r_run_mode <= RST_RUN;
        end else begin
            r_state    <= w_state_nxt;
            r_run_mode <= w_run_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 4'b0000;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_fetch && bus.MEM_READY)
                r_op <= bus.IR_IN;
            if (w_exec1 && (r_op >= OP_ILL_MIN))
                r_illegal <= 1'b1;
            if (w_instr_done)
                r_count <= r_count + 1'b1;
        end
    end

    // BREAK overrides START, and a BREAK in the final execute cycle still stops at this boundary.
    assign w_start     = bus.START & ~bus.BREAK;
    assign w_end_state = (r_run_mode & ~bus.BREAK) ? S_FETCH : S_IDLE;

    // NOTE: defaults first so no path leaves the combinational outputs unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_mode;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (w_start) begin
                    w_state_nxt = S_FETCH;
                    w_run_nxt   = 1'b1;
                end else if (bus.STEP) begin
                    w_state_nxt = S_FETCH;
                    w_run_nxt   = 1'b0;
                end
            end
            S_FETCH: begin
                if (bus.BREAK)
                    w_run_nxt = 1'b0;
                if (bus.MEM_READY)
                    w_state_nxt = S_EXEC1;
            end
            S_EXEC1: begin
                if (bus.BREAK)
                    w_run_nxt = 1'b0;
                if (r_op == OP_LDA)
                    w_state_nxt = S_EXEC2;
                else if (r_op == OP_STP)
                    w_state_nxt = S_HALT;
                else
                    w_state_nxt = w_end_state;
            end
            S_EXEC2: begin
                if (bus.BREAK)
                    w_run_nxt = 1'b0;
                w_state_nxt = w_end_state;
            end
            default: begin
                w_state_nxt = RST_STATE;
                w_run_nxt   = RST_RUN;
            end
        endcase
    end

    always_comb begin
        w_fetch      = (r_state == S_FETCH);
        w_exec1      = (r_state == S_EXEC1);
        w_exec2      = (r_state == S_EXEC2);
        w_halted     = (r_state == S_HALT);
        w_instr_done = (w_exec1 && (r_op != OP_LDA)) || w_exec2;
    end

    assign bus.FETCH       = w_fetch;
    assign bus.EXEC1       = w_exec1;
    assign bus.EXEC2       = w_exec2;
    assign bus.OP          = r_op;
    assign bus.HALTED      = w_halted;
    assign bus.ILLEGAL     = r_illegal;
    assign bus.INSTR_DONE  = w_instr_done;
    assign bus.INSTR_COUNT = r_count;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus random control traffic,
// compared each cycle against an instruction-level reference model.
module tb_cpu_sequencer;
    localparam int ICNT_W = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    cpu_sequencer_if #(.ICNT_W(ICNT_W)) bus ();
    cpu_sequencer_if #(.ICNT_W(16))     bus2 ();

    cpu_sequencer #(.ICNT_W(ICNT_W), .AUTO_START(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    cpu_sequencer #(.ICNT_W(16), .AUTO_START(1'b1)) dut_auto (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an instruction is either being fetched (m_exec == 0) or in its
    // m_exec-th execute cycle; its execute length comes from the opcode.
    bit       m_busy;
    bit       m_halted;
    bit       m_run;
    bit       m_illegal;
    int       m_exec;
    int       m_count;
    bit [3:0] m_op;

    function automatic int exec_len(bit [3:0] op);
        return (op == 4'd0) ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_halted = 0; m_run = 0; m_illegal = 0;
        m_exec = 0; m_count = 0; m_op = 4'd0;
    endtask

    task automatic model_step(bit st, bit sp, bit bk, bit rd, bit [3:0] ir);
        if (!m_busy) begin
            if ((st && !bk) || sp) begin
                m_busy = 1; m_exec = 0; m_halted = 0;
                m_run = st && !bk;
            end
        end else begin
            if (bk) m_run = 0;
            if (m_exec == 0) begin
                if (rd) begin
                    m_op = ir;
                    m_exec = 1;
                end
            end else if (m_exec == exec_len(m_op)) begin
                m_count = (m_count + 1) % (1 << ICNT_W);
                if (m_op >= 4'd11) m_illegal = 1;
                if (m_op == 4'd7) begin
                    m_halted = 1; m_busy = 0;
                end else if (m_run) begin
                    m_exec = 0;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_exec = m_exec + 1;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        bit done;
        done = m_busy && (m_exec > 0) && (m_exec == exec_len(m_op));
        check({tag, ".FETCH"},       32'(bus.FETCH),       32'(m_busy && m_exec == 0));
        check({tag, ".EXEC1"},       32'(bus.EXEC1),       32'(m_busy && m_exec == 1));
        check({tag, ".EXEC2"},       32'(bus.EXEC2),       32'(m_busy && m_exec == 2));
        check({tag, ".OP"},          32'(bus.OP),          32'(m_op));
        check({tag, ".HALTED"},      32'(bus.HALTED),      32'(m_halted));
        check({tag, ".ILLEGAL"},     32'(bus.ILLEGAL),     32'(m_illegal));
        check({tag, ".INSTR_DONE"},  32'(bus.INSTR_DONE),  32'(done));
        check({tag, ".INSTR_COUNT"}, 32'(bus.INSTR_COUNT), 32'(m_count));
    endtask

    // One clock cycle: apply inputs, compare outputs, advance model, cross the edge.
    task automatic cyc(string tag, bit st, bit sp, bit bk, bit rd, bit [3:0] ir);
        bus.START = st; bus.STEP = sp; bus.BREAK = bk; bus.MEM_READY = rd; bus.IR_IN = ir;
        #1;
        check_all(tag);
        model_step(st, sp, bk, rd, ir);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.START = 0; bus.STEP = 0; bus.BREAK = 0; bus.MEM_READY = 1; bus.IR_IN = 4'd0;
        bus2.START = 0; bus2.STEP = 0; bus2.BREAK = 0; bus2.MEM_READY = 0; bus2.IR_IN = 4'd0;
        rst_n = 0;
        model_reset();
        #12;
        check_all("reset");
        check("auto_start.FETCH", 32'(bus2.FETCH), 32'd1);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Program 0010, 0000 (LDA), 0111 (STP) free-running into HALT.
        cyc("p1", 1, 0, 0, 1, 4'b0010);
        cyc("p1", 0, 0, 0, 1, 4'b0010);
        cyc("p1", 0, 0, 0, 1, 4'b0000);
        cyc("p1", 0, 0, 0, 1, 4'b0000);
        cyc("p1", 0, 0, 0, 1, 4'b0111);
        cyc("p1", 0, 0, 0, 1, 4'b0111);
        cyc("p1", 0, 0, 0, 1, 4'b0111);
        cyc("p1", 0, 0, 0, 1, 4'b0111);
        check("p1.count_is_3",  32'(bus.INSTR_COUNT), 32'd3);
        check("p1.halted",      32'(bus.HALTED),      32'd1);
        check("p1.op_stp",      32'(bus.OP),          32'h7);
        check("auto_start.hold", 32'(bus2.FETCH),     32'd1);

        // Resume from HALT with three wait states, BREAK on the ready edge.
        cyc("wait", 1, 0, 0, 0, 4'b0001);
        cyc("wait", 0, 0, 0, 0, 4'b0001);
        cyc("wait", 0, 0, 0, 0, 4'b0001);
        cyc("wait", 0, 0, 0, 0, 4'b0001);
        check("wait.op_held", 32'(bus.OP), 32'h7);
        cyc("wait", 0, 0, 1, 1, 4'b0001);
        check("wait.exec1", 32'(bus.EXEC1), 32'd1);
        cyc("wait", 0, 0, 0, 1, 4'b0001);

        // Single step, then no fetch without a new pulse.
        cyc("step", 0, 1, 0, 1, 4'b0001);
        cyc("step", 0, 0, 0, 1, 4'b0001);
        cyc("step", 0, 0, 0, 1, 4'b0001);
        cyc("step", 0, 0, 0, 1, 4'b0001);
        cyc("step", 0, 0, 0, 1, 4'b0001);
        check("step.idle_no_fetch", 32'(bus.FETCH), 32'd0);

        // BREAK during EXEC1 of LDA: EXEC2 still completes.
        cyc("brk", 1, 0, 0, 1, 4'b0000);
        cyc("brk", 0, 0, 0, 1, 4'b0000);
        cyc("brk", 0, 0, 1, 1, 4'b0000);
        check("brk.exec2", 32'(bus.EXEC2), 32'd1);
        cyc("brk", 0, 0, 0, 1, 4'b0000);
        cyc("brk", 0, 0, 0, 1, 4'b0000);
        // START together with BREAK while running.
        cyc("stbrk", 1, 0, 0, 1, 4'b0011);
        cyc("stbrk", 1, 0, 1, 1, 4'b0011);
        cyc("stbrk", 0, 0, 0, 1, 4'b0011);
        cyc("stbrk", 0, 0, 0, 1, 4'b0011);

        // Undefined opcode, then a legal one: ILLEGAL stays set.
        cyc("ill", 0, 1, 0, 1, 4'b1100);
        cyc("ill", 0, 0, 0, 1, 4'b1100);
        cyc("ill", 0, 0, 0, 1, 4'b0010);
        cyc("ill", 0, 1, 0, 1, 4'b0010);
        cyc("ill", 0, 0, 0, 1, 4'b0010);
        cyc("ill", 0, 0, 0, 1, 4'b0010);
        check("ill.sticky", 32'(bus.ILLEGAL), 32'd1);

        // Random control traffic.
        for (int i = 0; i < 400; i++) begin
            cyc("rnd", ($urandom_range(7) == 0), ($urandom_range(7) == 0),
                ($urandom_range(9) == 0), ($urandom_range(3) != 0),
                4'($urandom_range(15)));
        end

        // Asynchronous reset in the middle of EXEC2.
        cyc("arst", 1, 0, 1, 1, 4'b0101);
        cyc("arst", 0, 0, 0, 1, 4'b0101);
        cyc("arst", 0, 0, 0, 1, 4'b0101);
        cyc("arst", 1, 0, 0, 1, 4'b0000);
        cyc("arst", 0, 0, 0, 1, 4'b0000);
        cyc("arst", 0, 0, 0, 1, 4'b0000);
        check("arst.in_exec2", 32'(bus.EXEC2), 32'd1);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all("arst.now");
        check("arst.count0", 32'(bus.INSTR_COUNT), 32'd0);
        #3;
        rst_n = 1;
        @(posedge clk);
        #1;

        // Seventeen single-stepped instructions wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            cyc("wrap", 0, 1, 0, 1, 4'b1001);
            cyc("wrap", 0, 0, 0, 1, 4'b1001);
            cyc("wrap", 0, 0, 0, 1, 4'b1001);
        end
        check("wrap.count_is_1", 32'(bus.INSTR_COUNT), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Timing/phase generator for the MU0 control unit: produces the one-hot FETCH/EXEC1/EXEC2 phase strobes and the latched opcode OP[15:12] that the instruction decoder consumes.
- Sequences each instruction: fetch with a memory-ready handshake, then one or two execute cycles chosen by opcode.
- Handles STP halt, single-step and break control, and counts retired instructions.
- Sits between memory/IR and the decoder in the CPU top level.

Parameters:
- ICNT_W, 16, width of retired-instruction counter
- AUTO_START, 0, 1 = leave reset directly into free-running FETCH; 0 = leave reset into IDLE

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- START  input  1  pulse: begin/resume free-running execution
- STEP  input  1  pulse: execute exactly one instruction, then return to IDLE
- BREAK  input  1  pulse: stop at the next instruction boundary
- MEM_READY  input  1  instruction word valid on IR_IN this cycle
- IR_IN  input  4  opcode field [15:12] of the word being fetched
- FETCH  output  1  fetch phase strobe
- EXEC1  output  1  first execute phase strobe
- EXEC2  output  1  second execute phase strobe
- OP  output  4  latched opcode [15:12], stable through EXEC1/EXEC2
- HALTED  output  1  high while in HALT (after STP)
- ILLEGAL  output  1  sticky flag: undefined opcode executed
- INSTR_DONE  output  1  high during the final execute cycle of each instruction
- INSTR_COUNT  output  ICNT_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, EXEC1, EXEC2, HALT. The FETCH, EXEC1 and EXEC2 outputs are decoded directly from state, are mutually exclusive, and are all low in IDLE/HALT.
- Internal run_mode register: 1 = free-run, 0 = single-step/break pending.
- Reset (async, immediate, also mid-instruction):
  - State = FETCH with run_mode=1 if AUTO_START=1; otherwise IDLE with run_mode=0.
  - OP=4'b0000, HALTED=0, ILLEGAL=0, INSTR_COUNT=0.
- IDLE:
  - START → FETCH, run_mode=1.
  - Else STEP → FETCH, run_mode=0.
  - START and STEP in the same cycle: START wins.
- FETCH:
  - Held while MEM_READY=0; strobe stays high.
  - On a clock edge with MEM_READY=1: OP<=IR_IN, go to EXEC1.
  - OP changes only on this edge.
- EXEC1, by OP:
  - 0000 (LDA) → EXEC2.
  - 0111 (STP) → HALT; HALTED rises on that edge.
  - 0001–0110, 1000–1010 → end of instruction.
  - 1011–1111 → treated as NOP: end of instruction, ILLEGAL set (sticky until reset).
- EXEC2: always end of instruction.
- End of instruction: go to FETCH if run_mode=1, else IDLE.
- INSTR_DONE:
  - Combinational.
  - High in EXEC1 when OP≠0000, and in EXEC2.
  - STP counts as retired.
- INSTR_COUNT: increments on each edge where INSTR_DONE=1; wraps 2^ICNT_W−1 → 0.
- BREAK:
  - Any cycle outside IDLE/HALT clears run_mode, so the current instruction completes and the sequencer enters IDLE.
  - BREAK with START in the same cycle: BREAK wins.
  - BREAK in IDLE/HALT has no effect.
- START/STEP outside IDLE/HALT are ignored.
- HALT:
  - START → FETCH with run_mode=1, HALTED cleared; STEP → FETCH with run_mode=0, HALTED cleared.
  - OP holds 0111 until the next fetch completes.
- Latency: zero-wait instruction takes 2 cycles (3 for LDA), plus one per MEM_READY=0 cycle.

Test Plan:
- Reset with AUTO_START=0, MEM_READY=1, START pulse, IR_IN sequence 0010, 0000, 0111 → phases F,E1,F,E1,E2,F,E1,HALT; INSTR_DONE pulses 3×; INSTR_COUNT=3; HALTED=1; OP=0111.
- MEM_READY low for 3 cycles during FETCH → FETCH high 4 cycles, OP unchanged until the ready edge, then EXEC1.
- STEP in IDLE with IR_IN=0001 → F,E1,IDLE; INSTR_COUNT +1; no further FETCH without a new pulse.
- BREAK asserted during EXEC1 of LDA while free-running → EXEC2 completes, then IDLE; START+BREAK same cycle → IDLE.
- IR_IN=1100 → single EXEC1, ILLEGAL=1 and remains 1 across later legal instructions; INSTR_COUNT increments.
- rst_n low mid-EXEC2 → all strobes 0 immediately, OP=0000, count 0; ICNT_W=4 run of 17 instructions → INSTR_COUNT=1 (wrap).
